// File: rtl/projectile_pool_pkg.sv
// ff_pkg: shared coordinate, slot state and slot record types for the projectile pool
package ff_pkg;
  typedef logic [9:0] coord_t;
  typedef enum logic {SLOT_IDLE, SLOT_FLYING} slot_state_e;
  typedef struct packed {
    slot_state_e state;
    coord_t      x;
    coord_t      y;
    logic        dir;
  } slot_t;
  localparam int SCREEN_X_MAX = 639;
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/projectile_pool_if.sv
// projectile_pool_if: shooter/target/pixel bundle between the fighter, the pool and the color mapper; hit_count under PROJ_HIT_COUNT_EN
interface projectile_pool_if;
  import ff_pkg::*;
  logic       frame_clk, shoot, facing_left;
  coord_t     shooter_x, shooter_y, target_x, target_y, target_x_size, DrawX, DrawY;
  logic       is_proj, hit_pulse;
  logic [3:0] active_count;
`ifdef PROJ_HIT_COUNT_EN
  logic [7:0] hit_count;
  modport master (output frame_clk, shoot, facing_left, shooter_x, shooter_y, target_x, target_y,
                  target_x_size, DrawX, DrawY, input is_proj, hit_pulse, active_count, hit_count);
  modport slave (input frame_clk, shoot, facing_left, shooter_x, shooter_y, target_x, target_y,
                 target_x_size, DrawX, DrawY, output is_proj, hit_pulse, active_count, hit_count);
`else
  modport master (output frame_clk, shoot, facing_left, shooter_x, shooter_y, target_x, target_y,
                  target_x_size, DrawX, DrawY, input is_proj, hit_pulse, active_count);
  modport slave (input frame_clk, shoot, facing_left, shooter_x, shooter_y, target_x, target_y,
                 target_x_size, DrawX, DrawY, output is_proj, hit_pulse, active_count);
`endif
endinterface

// File: rtl/projectile_pool_slot.sv
// projectile_slot: one projectile's IDLE/FLYING state, per-frame motion, screen-edge retire, target hit test and pixel term
module projectile_slot
  import ff_pkg::*;
#(
  parameter int PROJ_STEP = 4,
  parameter int PROJ_SIZE = 4,
  parameter int X_MAX     = SCREEN_X_MAX
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   tick_i,
  input  logic   spawn_i,
  input  coord_t x_i,
  input  coord_t y_i,
  input  logic   dir_i,
  input  coord_t target_x_i,
  input  coord_t target_y_i,
  input  coord_t target_x_size_i,
  input  coord_t draw_x_i,
  input  coord_t draw_y_i,
  output logic   flying_o,
  output logic   flying_nx_o,
  output logic   hit_o,
  output logic   pix_o
);
  slot_t  s_q, s_d;
  coord_t nx;
  logic   moving, edge_out, hit_d;
  assign flying_o    = s_q.state == SLOT_FLYING;
  assign nx          = s_q.dir ? s_q.x - coord_t'(PROJ_STEP) : s_q.x + coord_t'(PROJ_STEP);
  assign edge_out    = s_q.dir ? (s_q.x < coord_t'(PROJ_STEP)) : (s_q.x > coord_t'(X_MAX - PROJ_STEP));
  assign hit_d       = (11'(abs_diff(nx, target_x_i)) <= 11'(target_x_size_i) + 11'(PROJ_SIZE)) &&
                       (abs_diff(s_q.y, target_y_i) <= coord_t'(PROJ_SIZE));
  assign moving      = tick_i & flying_o;
  assign hit_o       = moving & ~edge_out & hit_d;
  assign flying_nx_o = s_d.state == SLOT_FLYING;
  assign pix_o       = flying_o && (abs_diff(draw_x_i, s_q.x) <= coord_t'(PROJ_SIZE)) &&
                       (abs_diff(draw_y_i, s_q.y) <= coord_t'(PROJ_SIZE));
  // next slot record: load on spawn, otherwise step and retire on edge or hit
  always_comb begin
    s_d = s_q;
    if (spawn_i) s_d = '{state: SLOT_FLYING, x: x_i, y: y_i, dir: dir_i};
    else if (moving) begin
      s_d.x     = edge_out ? s_q.x : nx;
      s_d.state = (edge_out || hit_d) ? SLOT_IDLE : SLOT_FLYING;
    end
  end
  // slot register, cleared to an idle projectile at the origin
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) s_q <= '{state: SLOT_IDLE, x: '0, y: '0, dir: 1'b0};
    else          s_q <= s_d;
endmodule

// File: rtl/projectile_pool.sv
// projectile_pool: NUM_PROJ-slot projectile pool with fire cooldown, hit pulse and occupancy count; PROJ_HIT_COUNT_EN adds a saturating hit_count
module projectile_pool
  import ff_pkg::*;
#(
  parameter int NUM_PROJ        = 4,
  parameter int PROJ_STEP       = 4,
  parameter int PROJ_SIZE       = 4,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int X_MAX           = SCREEN_X_MAX
) (
  input logic             Clk,
  input logic             Reset_n,
  projectile_pool_if.slave bus
);
  logic                frame_q, shoot_q, pending_q, pending_d, hit_pulse_q;
  logic [7:0]          cd_q, cd_d;
  logic [3:0]          count_q, count_d;
  logic [NUM_PROJ-1:0] flying, flying_nx, hit, pix, spawn;
  logic                tick, shoot_edge, can_spawn, taken;
  assign tick       = bus.frame_clk & ~frame_q;
  assign shoot_edge = bus.shoot & ~shoot_q;
  assign can_spawn  = tick & pending_q & (cd_q == '0) & ~&flying;
  assign pending_d  = shoot_edge | (pending_q & ~tick);
  assign cd_d       = !tick ? cd_q : |spawn ? 8'(COOLDOWN_FRAMES) : (cd_q != '0) ? cd_q - 8'd1 : cd_q;
  // lowest-index slot idle at the start of the tick takes the spawn
  always_comb begin
    spawn = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      spawn[i] = can_spawn & ~flying[i] & ~taken;
      taken    = taken | spawn[i];
    end
  end
  // occupancy after this cycle's updates
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_PROJ; i++) count_d = count_d + 4'(flying_nx[i]);
  end
  for (genvar g = 0; g < NUM_PROJ; g++) begin : g_slot
    projectile_slot #(.PROJ_STEP(PROJ_STEP), .PROJ_SIZE(PROJ_SIZE), .X_MAX(X_MAX)) u_slot (
      .Clk(Clk), .Reset_n(Reset_n), .tick_i(tick), .spawn_i(spawn[g]),
      .x_i(bus.shooter_x), .y_i(bus.shooter_y), .dir_i(bus.facing_left),
      .target_x_i(bus.target_x), .target_y_i(bus.target_y), .target_x_size_i(bus.target_x_size),
      .draw_x_i(bus.DrawX), .draw_y_i(bus.DrawY),
      .flying_o(flying[g]), .flying_nx_o(flying_nx[g]), .hit_o(hit[g]), .pix_o(pix[g])
    );
  end
  // edge detectors, fire request, cooldown and registered status outputs
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      frame_q     <= 1'b0;
      shoot_q     <= 1'b0;
      pending_q   <= 1'b0;
      cd_q        <= '0;
      count_q     <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      frame_q     <= bus.frame_clk;
      shoot_q     <= bus.shoot;
      pending_q   <= pending_d;
      cd_q        <= cd_d;
      count_q     <= count_d;
      hit_pulse_q <= |hit;
    end
  assign bus.is_proj      = |pix;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.active_count = count_q;
`ifdef PROJ_HIT_COUNT_EN
  logic [7:0] hc_q, hc_d;
  logic [3:0] hits_n;
  // hits this cycle added into a counter that sticks at 255
  always_comb begin
    hits_n = '0;
    for (int i = 0; i < NUM_PROJ; i++) hits_n = hits_n + 4'(hit[i]);
    hc_d = (9'(hc_q) + 9'(hits_n) > 9'd255) ? 8'd255 : hc_q + 8'(hits_n);
  end
  // hit counter register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) hc_q <= '0;
    else          hc_q <= hc_d;
  assign bus.hit_count = hc_q;
`endif
endmodule
